// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P platform types used by the MMIO CSR responder.
// Field names and widths follow the platform interface definitions.
package ccip_if_pkg;

   typedef logic [27:0] t_ccip_c0_RspMemHdr;

   typedef struct packed {
      logic [15:0] address;
      logic [1:0]  length;
      logic        rsvd0;
      logic [8:0]  tid;
   } t_ccip_c0_ReqMmioHdr;

   typedef struct packed {
      t_ccip_c0_RspMemHdr hdr;
      logic [511:0]       data;
      logic               rspValid;
      logic               mmioRdValid;
      logic               mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c0_Rx c0;
   } t_if_ccip_Rx;

   typedef struct packed {
      logic [8:0] tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic                mmioRdValid;
      logic [63:0]         data;
   } t_if_ccip_c2_Tx;

endpackage

// File: rtl/ccip_mmio_csr_responder.sv
// Host MMIO responder: small CSR file (DFH, AFU ID, scratch, control, activity counters)
// with fixed two-cycle read completions on C2.
module ccip_mmio_csr_responder
   import ccip_if_pkg::*;
#(
   parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_1000,
   parameter logic [63:0] AFU_ID_L  = 64'h0,
   parameter logic [63:0] AFU_ID_H  = 64'h0
) (
   input  logic           afu_clk,
   input  logic           afu_softreset,
   input  t_if_ccip_Rx    afu_rx,
   output t_if_ccip_c2_Tx afu_tx_c2,
   output logic [63:0]    csr_ctrl,
   output logic           csr_ctrl_wr
);

   localparam logic [14:0] IdxDfh      = 15'd0;
   localparam logic [14:0] IdxAfuIdL   = 15'd1;
   localparam logic [14:0] IdxAfuIdH   = 15'd2;
   localparam logic [14:0] IdxScratch0 = 15'd5;
   localparam logic [14:0] IdxScratch1 = 15'd6;
   localparam logic [14:0] IdxCtrl     = 15'd7;
   localparam logic [14:0] IdxRdCnt    = 15'd8;
   localparam logic [14:0] IdxWrCnt    = 15'd9;
   localparam logic [14:0] IdxCntClr   = 15'd10;

   t_ccip_c0_ReqMmioHdr req_hdr;
   logic                wr_req, rd_req, wr_ok, wr_odd;
   logic [63:0]         wr_data;

   logic [63:0] scratch0_q, scratch0_d, scratch1_q, scratch1_d, ctrl_q, ctrl_d;
   logic        ctrl_wr_q, ctrl_wr_d, cnt_clr;
   logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

   logic        s0_valid_q;
   logic [15:0] s0_addr_q;
   logic [1:0]  s0_len_q;
   logic [8:0]  s0_tid_q;
   logic        s1_valid_q;
   logic [8:0]  s1_tid_q;
   logic [63:0] s1_data_q;
   logic [63:0] rd_sel, rd_data;

   logic unused_rx;

   function automatic logic size_ok(input logic odd, input logic [1:0] len);
      return (len == 2'd0) || ((len == 2'd1) && !odd);
   endfunction

   function automatic logic [63:0] merge_wr(input logic [63:0] old, input logic odd,
                                            input logic [1:0] len, input logic [63:0] data);
      if (len == 2'd1) return data;
      else if (odd) return {data[31:0], old[31:0]};
      else return {old[63:32], data[31:0]};
   endfunction

   assign req_hdr = t_ccip_c0_ReqMmioHdr'(afu_rx.c0.hdr);
   assign wr_data = afu_rx.c0.data[63:0];
   assign wr_odd  = req_hdr.address[0];
   assign wr_req  = afu_rx.c0.mmioWrValid;
   // A read colliding with a write is dropped outright.
   assign rd_req  = afu_rx.c0.mmioRdValid & ~afu_rx.c0.mmioWrValid;
   assign wr_ok   = wr_req & size_ok(wr_odd, req_hdr.length);

   assign unused_rx = ^{afu_rx.c0TxAlmFull, afu_rx.c1TxAlmFull, afu_rx.c0.data[511:64],
                        afu_rx.c0.rspValid, req_hdr.rsvd0};

   always_comb begin
      scratch0_d = scratch0_q;
      scratch1_d = scratch1_q;
      ctrl_d     = ctrl_q;
      ctrl_wr_d  = 1'b0;
      cnt_clr    = 1'b0;
      if (wr_ok) begin
         case (req_hdr.address[15:1])
            IdxScratch0: scratch0_d = merge_wr(scratch0_q, wr_odd, req_hdr.length, wr_data);
            IdxScratch1: scratch1_d = merge_wr(scratch1_q, wr_odd, req_hdr.length, wr_data);
            IdxCtrl: begin
               ctrl_d    = merge_wr(ctrl_q, wr_odd, req_hdr.length, wr_data);
               ctrl_wr_d = 1'b1;
            end
            IdxCntClr: cnt_clr = 1'b1;
            default: ;
         endcase
      end
      // Reads count as they leave stage 0 so an RD_CNT read sees its pre-increment value;
      // a clear overrides any increment landing on the same edge.
      rd_cnt_d = cnt_clr ? 32'h0 : rd_cnt_q + 32'(s0_valid_q);
      wr_cnt_d = cnt_clr ? 32'h0 : wr_cnt_q + 32'(wr_req);
   end

   always_comb begin
      case (s0_addr_q[15:1])
         IdxDfh:      rd_sel = DFH_VALUE;
         IdxAfuIdL:   rd_sel = AFU_ID_L;
         IdxAfuIdH:   rd_sel = AFU_ID_H;
         IdxScratch0: rd_sel = scratch0_q;
         IdxScratch1: rd_sel = scratch1_q;
         IdxCtrl:     rd_sel = ctrl_q;
         IdxRdCnt:    rd_sel = {32'h0, rd_cnt_q};
         IdxWrCnt:    rd_sel = {32'h0, wr_cnt_q};
         default:     rd_sel = 64'h0;
      endcase
      if (!s0_valid_q || !size_ok(s0_addr_q[0], s0_len_q)) begin
         rd_data = 64'h0;
      end else if (s0_len_q == 2'd0) begin
         rd_data = {32'h0, s0_addr_q[0] ? rd_sel[63:32] : rd_sel[31:0]};
      end else begin
         rd_data = rd_sel;
      end
   end

   always_ff @(posedge afu_clk) begin
      if (afu_softreset) begin
         scratch0_q <= '0;
         scratch1_q <= '0;
         ctrl_q     <= '0;
         ctrl_wr_q  <= 1'b0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         s0_valid_q <= 1'b0;
         s0_addr_q  <= '0;
         s0_len_q   <= '0;
         s0_tid_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_tid_q   <= '0;
         s1_data_q  <= '0;
         afu_tx_c2  <= '0;
      end else begin
         scratch0_q <= scratch0_d;
         scratch1_q <= scratch1_d;
         ctrl_q     <= ctrl_d;
         ctrl_wr_q  <= ctrl_wr_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         s0_valid_q <= rd_req;
         s0_addr_q  <= req_hdr.address;
         s0_len_q   <= req_hdr.length;
         s0_tid_q   <= req_hdr.tid;
         s1_valid_q <= s0_valid_q;
         s1_tid_q   <= s0_valid_q ? s0_tid_q : 9'h0;
         s1_data_q  <= rd_data;
         afu_tx_c2.mmioRdValid <= s1_valid_q;
         afu_tx_c2.hdr.tid     <= s1_tid_q;
         afu_tx_c2.data        <= s1_data_q;
      end
   end

   assign csr_ctrl    = ctrl_q;
   assign csr_ctrl_wr = ctrl_wr_q;

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Directed bench for the MMIO CSR responder: latency, register map, counters and reset.
module tb_ccip_mmio_csr_responder;
   import ccip_if_pkg::*;

   localparam logic [63:0] DfhVal = 64'h1000_0000_0000_1000;
   localparam logic [63:0] IdLVal = 64'h1111_2222_3333_4444;
   localparam logic [63:0] IdHVal = 64'h5555_6666_7777_8888;

   logic           afu_clk = 1'b0;
   logic           afu_softreset;
   t_if_ccip_Rx    afu_rx;
   t_if_ccip_c2_Tx afu_tx_c2;
   logic [63:0]    csr_ctrl;
   logic           csr_ctrl_wr;

   int checks = 0;
   int failures = 0;
   logic [8:0]  rsp_tid_q[$];
   logic [63:0] rsp_data_q[$];

   logic [15:0] b_addr[16];
   logic [1:0]  b_len[16];
   logic [63:0] b_exp[16];

   ccip_mmio_csr_responder #(
      .DFH_VALUE(DfhVal),
      .AFU_ID_L (IdLVal),
      .AFU_ID_H (IdHVal)
   ) dut (
      .afu_clk      (afu_clk),
      .afu_softreset(afu_softreset),
      .afu_rx       (afu_rx),
      .afu_tx_c2    (afu_tx_c2),
      .csr_ctrl     (csr_ctrl),
      .csr_ctrl_wr  (csr_ctrl_wr)
   );

   always #5 afu_clk = ~afu_clk;

   always @(posedge afu_clk) begin
      #1;
      if (afu_tx_c2.mmioRdValid) begin
         rsp_tid_q.push_back(afu_tx_c2.hdr.tid);
         rsp_data_q.push_back(afu_tx_c2.data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
      t_ccip_c0_ReqMmioHdr h;
      h = '0;
      h.address = addr;
      h.length  = len;
      h.tid     = tid;
      afu_rx = '0;
      afu_rx.c0.hdr = h;
      afu_rx.c0.data = {448'h0, data};
      afu_rx.c0.mmioRdValid = rd;
      afu_rx.c0.mmioWrValid = wr;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
      set_req(rd, wr, addr, len, tid, data);
      @(negedge afu_clk);
      afu_rx = '0;
   endtask

   task automatic pop_rsp(output logic [8:0] tid, output logic [63:0] data);
      if (rsp_data_q.size() != 0) begin
         tid  = rsp_tid_q.pop_front();
         data = rsp_data_q.pop_front();
      end else begin
         tid  = 'x;
         data = 'x;
      end
   endtask

   task automatic rd_check(input string tag, input logic [15:0] addr, input logic [1:0] len,
                           input logic [8:0] tid, input logic [63:0] exp);
      logic [8:0]  got_tid;
      logic [63:0] got_data;
      drive(1'b1, 1'b0, addr, len, tid, 64'h0);
      for (int i = 0; i < 6 && rsp_data_q.size() == 0; i++) @(negedge afu_clk);
      pop_rsp(got_tid, got_data);
      check({tag, "_tid"}, 64'(got_tid), 64'(tid));
      check({tag, "_data"}, got_data, exp);
   endtask

   task automatic flush();
      rsp_tid_q.delete();
      rsp_data_q.delete();
   endtask

   initial begin
      logic [8:0]  t;
      logic [63:0] d;
      afu_rx = '0;
      afu_softreset = 1'b1;
      @(negedge afu_clk);
      // Write presented during reset must be ignored.
      drive(1'b0, 1'b1, 16'h0E, 2'd1, 9'h0, 64'h3);
      @(negedge afu_clk);
      afu_softreset = 1'b0;
      check("rst_valid", 64'(afu_tx_c2.mmioRdValid), 64'd0);
      check("rst_tx_all", 64'(afu_tx_c2), 64'd0);
      check("rst_ctrl", csr_ctrl, 64'd0);
      check("rst_ctrl_wr", 64'(csr_ctrl_wr), 64'd0);

      // Latency: response exactly two cycles after the sampling edge.
      flush();
      set_req(1'b1, 1'b0, 16'h00, 2'd1, 9'h05, 64'h0);
      @(negedge afu_clk);
      afu_rx = '0;
      check("lat_n0_valid", 64'(afu_tx_c2.mmioRdValid), 64'd0);
      @(negedge afu_clk);
      check("lat_n1_valid", 64'(afu_tx_c2.mmioRdValid), 64'd0);
      @(negedge afu_clk);
      check("lat_n2_valid", 64'(afu_tx_c2.mmioRdValid), 64'd1);
      check("lat_n2_tid", 64'(afu_tx_c2.hdr.tid), 64'h05);
      check("lat_n2_data", afu_tx_c2.data, DfhVal);
      @(negedge afu_clk);
      check("idle_tx_zero", 64'(afu_tx_c2.hdr.tid) | afu_tx_c2.data, 64'd0);
      check("idle_valid", 64'(afu_tx_c2.mmioRdValid), 64'd0);
      flush();

      // Scratch dword merging and read-after-write.
      drive(1'b0, 1'b1, 16'h0A, 2'd1, 9'h0, 64'hDEAD_BEEF_0123_4567);
      drive(1'b0, 1'b1, 16'h0B, 2'd0, 9'h0, 64'h0000_0000_AAAA_5555);
      rd_check("scr0_lo4", 16'h0A, 2'd0, 9'h10, 64'h0000_0000_0123_4567);
      rd_check("scr0_hi4", 16'h0B, 2'd0, 9'h11, 64'h0000_0000_AAAA_5555);
      rd_check("scr0_8b", 16'h0A, 2'd1, 9'h12, 64'hAAAA_5555_0123_4567);
      drive(1'b0, 1'b1, 16'h0C, 2'd1, 9'h0, 64'hCAFE_F00D_1234_5678);
      rd_check("raw_scr1", 16'h0C, 2'd1, 9'h13, 64'hCAFE_F00D_1234_5678);

      // Back-to-back reads across the map, including illegal and unmapped accesses.
      b_addr = '{16'h00, 16'h02, 16'h04, 16'h06, 16'h08, 16'h0A, 16'h0C, 16'h0E,
                 16'h14, 16'h100, 16'h0B, 16'h0D, 16'h0C, 16'h0A, 16'h03, 16'h01};
      b_len  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
      b_exp  = '{DfhVal, IdLVal, IdHVal, 64'h0, 64'h0, 64'hAAAA_5555_0123_4567,
                 64'hCAFE_F00D_1234_5678, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0000_0000_CAFE_F00D,
                 64'h0000_0000_1234_5678, 64'h0, 64'h0000_0000_1111_2222, 64'h0000_0000_1000_0000};
      flush();
      for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, b_addr[i], b_len[i], 9'(i), 64'h0);
      repeat (4) @(negedge afu_clk);
      check("b2b_count", 64'(rsp_data_q.size()), 64'd16);
      for (int i = 0; i < 16; i++) begin
         pop_rsp(t, d);
         check($sformatf("b2b%0d_tid", i), 64'(t), 64'(i));
         check($sformatf("b2b%0d_data", i), d, b_exp[i]);
      end

      // Counters from a clean reset.
      afu_softreset = 1'b1;
      repeat (2) @(negedge afu_clk);
      afu_softreset = 1'b0;
      flush();
      drive(1'b0, 1'b1, 16'h0E, 2'd1, 9'h0, 64'h3);
      check("ctrl_val", csr_ctrl, 64'h3);
      check("ctrl_wr_pulse", 64'(csr_ctrl_wr), 64'd1);
      @(negedge afu_clk);
      check("ctrl_wr_single", 64'(csr_ctrl_wr), 64'd0);
      drive(1'b0, 1'b1, 16'h0F, 2'd0, 9'h0, 64'h0);
      check("ctrl_wr_4b_pulse", 64'(csr_ctrl_wr), 64'd1);
      check("ctrl_val_4b", csr_ctrl, 64'h3);
      drive(1'b0, 1'b1, 16'h00, 2'd1, 9'h0, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b0, 1'b1, 16'h100, 2'd1, 9'h0, 64'h1234);
      rd_check("ro_dfh", 16'h00, 2'd1, 9'h30, DfhVal);
      rd_check("ctrl_rd", 16'h0E, 2'd1, 9'h31, 64'h3);
      rd_check("rd_cnt", 16'h10, 2'd1, 9'h32, 64'd2);
      rd_check("wr_cnt", 16'h12, 2'd1, 9'h33, 64'd4);
      drive(1'b0, 1'b1, 16'h14, 2'd1, 9'h0, 64'h1);
      rd_check("wr_cnt_clr", 16'h12, 2'd1, 9'h34, 64'd0);
      rd_check("rd_cnt_clr", 16'h10, 2'd1, 9'h35, 64'd1);

      // RD_CNT wrap.
      force dut.rd_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.rd_cnt_q;
      rd_check("rd_cnt_max", 16'h10, 2'd1, 9'h36, 64'h0000_0000_FFFF_FFFF);
      rd_check("rd_cnt_wrap", 16'h10, 2'd1, 9'h37, 64'd0);

      // Reset with two reads in flight.
      drive(1'b0, 1'b1, 16'h0A, 2'd1, 9'h0, 64'h0BAD_F00D_5555_AAAA);
      flush();
      set_req(1'b1, 1'b0, 16'h0A, 2'd1, 9'h21, 64'h0);
      @(negedge afu_clk);
      set_req(1'b1, 1'b0, 16'h0C, 2'd1, 9'h22, 64'h0);
      @(negedge afu_clk);
      afu_rx = '0;
      afu_softreset = 1'b1;
      repeat (2) @(negedge afu_clk);
      check("rst_flight_tx", 64'(afu_tx_c2), 64'd0);
      afu_softreset = 1'b0;
      repeat (6) @(negedge afu_clk);
      check("rst_flight_norsp", 64'(rsp_data_q.size()), 64'd0);
      check("rst_ctrl_clear", csr_ctrl, 64'd0);
      rd_check("rst_scr0", 16'h0A, 2'd1, 9'h23, 64'd0);

      // Simultaneous read and write: write wins, read gets no response.
      flush();
      drive(1'b1, 1'b1, 16'h0C, 2'd1, 9'h1AA, 64'h7777_8888_9999_AAAA);
      repeat (5) @(negedge afu_clk);
      check("rdwr_norsp", 64'(rsp_data_q.size()), 64'd0);
      rd_check("rdwr_scr1", 16'h0C, 2'd1, 9'h24, 64'h7777_8888_9999_AAAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ccip_mmio_csr_responder.md
# ccip_mmio_csr_responder

Single-clock CCI-P MMIO responder on the AFU side of the clock-crossing shim. It decodes host MMIO reads and writes arriving on the C0 Rx channel and maintains a small CSR file with a device feature header, AFU ID, scratch, control and activity counters. It returns read completions on the C2 Tx channel with the request's tid at a fixed two-cycle latency.

## Interface
Parameters:
- DFH_VALUE, 64'h1000_0000_0000_1000: read-only value at byte offset 0x000.
- AFU_ID_L, 64'h0: read-only value at 0x008.
- AFU_ID_H, 64'h0: read-only value at 0x010.

Ports:
- afu_clk  in  1  clock
- afu_softreset  in  1  reset; synchronous, active-high
- afu_rx  in  t_if_ccip_Rx  only c0 is used; c0.hdr is cast to t_ccip_c0_ReqMmioHdr (address[15:0] in DWORD units, length[1:0], tid[8:0])
- afu_tx_c2  out  t_if_ccip_c2_Tx  MMIO read response: hdr.tid, mmioRdValid, data[63:0]
- csr_ctrl  out  64  current CTRL register value
- csr_ctrl_wr  out  1  one-cycle pulse on any accepted CTRL write

## Operation
- Register map, byte offset = address*4, 8B aligned:
  - 0x000 DFH, RO
  - 0x008 AFU_ID_L, RO
  - 0x010 AFU_ID_H, RO
  - 0x018 and 0x020 RSVD, RO, read 0
  - 0x028 SCRATCH0, RW
  - 0x030 SCRATCH1, RW
  - 0x038 CTRL, RW
  - 0x040 RD_CNT, RO, bits[31:0]
  - 0x048 WR_CNT, RO, bits[31:0]
  - 0x050 CNT_CLR, write-only: any accepted write zeroes both counters; reads return 0.
- Access size, from length:
  - 0 = 4B, 1 = 8B, 2 = 64B (unsupported).
  - 8B access requires address[0]=0. 8B access with address[0]=1 is illegal.
  - 4B write: data[31:0] goes to the lower dword (address[0]=0) or the upper dword (address[0]=1). The other half is unchanged.
  - 4B read: the selected dword is returned in data[31:0]; data[63:32]=0.
- Illegal or unsupported accesses and unmapped offsets (address[15:1] beyond 0x050):
  - writes are ignored;
  - reads still complete, with data=0 and tid echoed.
- Writes to RO offsets are ignored.
- Counters:
  - RD_CNT increments on every read request, including illegal ones.
  - WR_CNT increments on every write request, including ignored ones.
  - Both are 32-bit and wrap 0xFFFF_FFFF -> 0.
  - A CNT_CLR write zeroes both counters. The WR_CNT increment for that same write is suppressed, so the result is 0.
- csr_ctrl_wr pulses for both 4B and 8B CTRL writes.
- mmioRdValid and mmioWrValid are never asserted in the same cycle. If both appear, the write is processed and the read is dropped (no response).

## Timing
- Read request sampled at edge N:
  - stage 1: decode and register select, registered at N+1;
  - afu_tx_c2.mmioRdValid=1 with data and tid registered at N+2.
- Back-to-back reads every cycle produce responses every cycle, in order. There is no backpressure on C2.
- A read in cycle N+1 following a write in cycle N returns the new value.
- A read of RD_CNT returns the count before that read's own increment.
- CSR update: write sampled at edge N is visible in csr_ctrl after edge N. csr_ctrl_wr is high for exactly that cycle.
- When no response is issued, afu_tx_c2.mmioRdValid=0, hdr=0 and data=0 (all fields are zeroed).
- Reset: when afu_softreset is high at an edge, the following are cleared:
  - afu_tx_c2 = 0;
  - SCRATCH0, SCRATCH1, CTRL, RD_CNT, WR_CNT = 0;
  - csr_ctrl = 0 and csr_ctrl_wr = 0;
  - both pipeline stages; reads in flight are dropped, with no response after reset deasserts.
- Requests present while reset is asserted are ignored.

## Test plan
- Reset, then 8B read of 0x000 with tid=0x05 -> two cycles later: mmioRdValid=1, tid=0x05, data=DFH_VALUE; all earlier cycles have mmioRdValid=0.
- 8B write 0xDEAD_BEEF_0123_4567 to 0x028, then 4B write 0xAAAA_5555 to address=0x0B (upper dword of 0x028), then 4B read of address=0x0A -> data=0x0000_0000_0123_4567; 8B read -> 0xAAAA_5555_0123_4567.
- 16 back-to-back reads with tids 0..15 cycling across all offsets, including 0x100 and an 8B read at an odd address -> 16 consecutive responses in order; unmapped and illegal reads return data=0.
- CTRL write 0x3 -> csr_ctrl=0x3 with a single-cycle csr_ctrl_wr pulse. Then 3 writes + 2 reads, then read WR_CNT=4 and RD_CNT=2. Then CNT_CLR write, then read WR_CNT -> 0.
- Preload RD_CNT to 0xFFFF_FFFF via forced state, issue a read -> RD_CNT wraps to 0. Assert afu_softreset with 2 reads in flight -> no responses emitted; SCRATCH0 reads 0 afterwards.
